// File: rtl/phase_sequencer_pkg.sv
// rtl/phase_sequencer_pkg.sv - shared constants for the phase sequencer
// Purpose: opcode classes, state encoding and widths used by the sequencer,
//          its opcode classifier, the decoder and the formal checks.
// Ports:   none (package).
package phase_sequencer_pkg;

  localparam int OP_W    = 5;
  localparam int STATE_W = 3;
  localparam int TMO_W   = 8;   // holds MUL_TIMEOUT up to 255

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [OP_W-1:0] OP_STP        = 5'b00000;
  localparam logic [OP_W-1:0] OP_MLR        = 5'b00111;
  localparam logic [OP_W-1:0] OP_LDR        = 5'b01110;
  localparam logic [2:0]      OP_LDA_PREFIX = 3'b110;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_FETCH    = 3'd1;
  localparam state_t S_EXEC1    = 3'd2;
  localparam state_t S_EXEC2    = 3'd3;
  localparam state_t S_MUL_WAIT = 3'd4;
  localparam state_t S_HALT     = 3'd5;

endpackage

// File: rtl/phase_sequencer_if.sv
// rtl/phase_sequencer_if.sv - control/strobe bundle between panel, sequencer and decoder
// Purpose: groups the sequencer control inputs and phase outputs.
// Ports:   master drives run/step/clear/stall/opcode/mul_done and observes
//          fe/e1/e2/mul_start/busy/halted/mul_err/instr_count;
//          slave (the sequencer) is the mirror image.
interface phase_sequencer_if
  import phase_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             run;
  logic             step;
  logic             clear;
  logic             stall;
  logic [OP_W-1:0]  opcode;
  logic             mul_done;
  logic             fe;
  logic             e1;
  logic             e2;
  logic             mul_start;
  logic             busy;
  logic             halted;
  logic             mul_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, step, clear, stall, opcode, mul_done,
    input  fe, e1, e2, mul_start, busy, halted, mul_err, instr_count
  );

  modport slave (
    input  run, step, clear, stall, opcode, mul_done,
    output fe, e1, e2, mul_start, busy, halted, mul_err, instr_count
  );

endinterface

// File: rtl/phase_op_class.sv
// rtl/phase_op_class.sv - opcode classifier for the phase sequencer
// Purpose: combinational map from INSTR[15:11] to the sequencing class.
// Ports:   opcode (in, 5) ; is_stp, is_two_phase, is_mul (out, 1 each).
module phase_op_class
  import phase_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            is_stp,
  output logic            is_two_phase,
  output logic            is_mul
);

  assign is_stp       = (opcode == OP_STP);
  assign is_mul       = (opcode == OP_MLR);
  // LDA is a whole opcode group (110xx); LDR is a single opcode.
  assign is_two_phase = (opcode == OP_LDR) || (opcode[4:2] == OP_LDA_PREFIX);

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - fetch/execute phase strobe generator
// Purpose: walks each instruction through FETCH, EXEC1 and optionally EXEC2
//          or a multiplier wait; handles run/single-step, STP halt and
//          multiplier timeout; counts retired instructions.
// Ports:   clk, reset_n (async active-low) ; bus (phase_sequencer_if.slave).
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int MUL_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  phase_sequencer_if.slave   bus
);

  state_t           state_q, state_d;
  logic             ss_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_stp, is_two_phase, is_mul;
  logic complete, timeout, ss_set, ss_clr, tmo_load, halt_clear;

  phase_op_class u_op_class (
    .opcode       (bus.opcode),
    .is_stp       (is_stp),
    .is_two_phase (is_two_phase),
    .is_mul       (is_mul)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    complete   = 1'b0;
    timeout    = 1'b0;
    ss_set     = 1'b0;
    ss_clr     = 1'b0;
    tmo_load   = 1'b0;
    halt_clear = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_FETCH;
          ss_clr  = 1'b1;
        end else if (bus.step) begin
          state_d = S_FETCH;
          ss_set  = 1'b1;
        end
      end
      S_FETCH: begin
        if (!bus.stall) state_d = S_EXEC1;
      end
      S_EXEC1: begin
        if (is_stp) begin
          state_d = S_HALT;
        end else if (is_two_phase) begin
          state_d = S_EXEC2;
        end else if (is_mul) begin
          state_d  = S_MUL_WAIT;
          tmo_load = 1'b1;
        end else begin
          complete = 1'b1;
        end
      end
      S_EXEC2: complete = 1'b1;
      S_MUL_WAIT: begin
        // A late mul_done on the last wait cycle still completes.
        if (bus.mul_done) begin
          complete = 1'b1;
        end else if (tmo_q == TMO_W'(1)) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (bus.clear) begin
          state_d    = S_IDLE;
          ss_clr     = 1'b1;
          halt_clear = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (complete) state_d = (ss_q || !bus.run) ? S_IDLE : S_FETCH;
  end

  always_comb begin
    bus.fe          = (state_q == S_FETCH);
    bus.e1          = (state_q == S_EXEC1);
    bus.e2          = (state_q == S_EXEC2);
    bus.mul_start   = (state_q == S_EXEC1) && is_mul;
    bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    bus.halted      = (state_q == S_HALT);
    bus.mul_err     = err_q;
    bus.instr_count = cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_q  <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
      cnt_q <= '0;
    end else begin
      if (ss_set)      ss_q <= 1'b1;
      else if (ss_clr) ss_q <= 1'b0;
      if (timeout)         err_q <= 1'b1;
      else if (halt_clear) err_q <= 1'b0;
      if (tmo_load)                      tmo_q <= TMO_W'(MUL_TIMEOUT);
      else if (state_q == S_MUL_WAIT)    tmo_q <= tmo_q - 1'b1;
      if (complete) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - scoreboard bench for phase_sequencer
// Purpose: directed cycle-by-cycle vectors; expected output words are queued
//          by the stimulus and popped/compared by a negedge monitor.
// Ports:   none (top-level bench).
module tb_phase_sequencer;

  localparam int CNT_W = 16;
  localparam int P_I = 0, P_F = 1, P_E1 = 2, P_E2 = 3, P_MS = 4, P_W = 5, P_H = 6;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(CNT_W)) bus ();

  phase_sequencer #(.MUL_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [22:0] v;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;
  int seq    = 0;

  // Word layout: {fe, e1, e2, mul_start, busy, halted, mul_err, instr_count}
  function automatic logic [22:0] ex(int ph, int cnt, bit err);
    logic [6:0] f;
    logic [31:0] c;
    c = cnt;
    case (ph)
      P_F:     f = 7'b1000100;
      P_E1:    f = 7'b0100100;
      P_E2:    f = 7'b0010100;
      P_MS:    f = 7'b0101100;
      P_W:     f = 7'b0000100;
      P_H:     f = 7'b0000010;
      default: f = 7'b0000000;
    endcase
    f[0] = err;
    return {f, c[15:0]};
  endfunction

  function automatic logic [22:0] act();
    return {bus.fe, bus.e1, bus.e2, bus.mul_start, bus.busy, bus.halted,
            bus.mul_err, bus.instr_count};
  endfunction

  task automatic chk(string name, logic [22:0] a, logic [22:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got fe/e1/e2/ms/busy/halt/err=%b cnt=%0d, expected %b cnt=%0d",
               name, a[22:16], a[15:0], e[22:16], e[15:0]);
    end
  endtask

  // Advance one clock; queue the outputs expected during the new cycle.
  task automatic adv(int ph, int cnt, bit err = 1'b0);
    exp_t e;
    @(posedge clk);
    #1;
    seq++;
    e.v  = ex(ph, cnt, err);
    e.id = seq;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk($sformatf("cycle_%0d", e.id), act(), e.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    bus.run      = 1'b0;
    bus.step     = 1'b0;
    bus.clear    = 1'b0;
    bus.stall    = 1'b0;
    bus.opcode   = 5'b00001;
    bus.mul_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", act(), 23'b0);
    reset_n = 1'b1;

    // Back-to-back ordinary instructions in run mode
    bus.run = 1'b1;
    adv(P_F, 0); adv(P_E1, 0); adv(P_F, 1); adv(P_E1, 1);
    bus.run = 1'b0;
    adv(P_I, 2);

    // LDA then LDR: three phases each
    bus.run = 1'b1; bus.opcode = 5'b11001;
    adv(P_F, 2); adv(P_E1, 2); adv(P_E2, 2);
    bus.opcode = 5'b01110;
    adv(P_F, 3); adv(P_E1, 3); adv(P_E2, 3);
    bus.run = 1'b0;
    adv(P_I, 4);

    // Single step; step held into FETCH/EXEC1 must be ignored
    bus.step = 1'b1; bus.opcode = 5'b00001;
    adv(P_F, 4); adv(P_E1, 4); adv(P_I, 5);
    bus.step = 1'b0;
    adv(P_I, 5);

    // run has priority over step in IDLE
    bus.run = 1'b1; bus.step = 1'b1;
    adv(P_F, 5);
    bus.step = 1'b0;
    adv(P_E1, 5); adv(P_F, 6);
    bus.run = 1'b0;
    adv(P_E1, 6); adv(P_I, 7);

    // Stall for three FETCH cycles
    bus.run = 1'b1; bus.stall = 1'b1;
    adv(P_F, 7); adv(P_F, 7); adv(P_F, 7); adv(P_F, 7);
    bus.stall = 1'b0; bus.run = 1'b0;
    adv(P_E1, 7); adv(P_I, 8);

    // MLR with mul_done five cycles after mul_start
    bus.run = 1'b1; bus.opcode = 5'b00111;
    adv(P_F, 8);
    bus.run = 1'b0;
    adv(P_MS, 8);
    for (int i = 0; i < 5; i++) adv(P_W, 8);
    bus.mul_done = 1'b1;
    adv(P_I, 9);
    adv(P_I, 9);
    bus.mul_done = 1'b0;

    // MLR timeout: 16 wait cycles then HALT with mul_err
    bus.run = 1'b1;
    adv(P_F, 9);
    bus.run = 1'b0;
    adv(P_MS, 9);
    for (int i = 0; i < 16; i++) adv(P_W, 9);
    adv(P_H, 9, 1'b1);
    bus.run = 1'b1; bus.step = 1'b1; bus.stall = 1'b1;
    adv(P_H, 9, 1'b1);
    bus.run = 1'b0; bus.step = 1'b0; bus.stall = 1'b0; bus.clear = 1'b1;
    adv(P_I, 9);
    bus.clear = 1'b0;
    adv(P_I, 9);

    // STP halts without counting
    bus.run = 1'b1; bus.opcode = 5'b00000;
    adv(P_F, 9); adv(P_E1, 9); adv(P_H, 9);
    bus.run = 1'b0;
    adv(P_H, 9);
    bus.clear = 1'b1;
    adv(P_I, 9);
    bus.clear = 1'b0;

    // Asynchronous reset during EXEC2 of an LDA
    bus.run = 1'b1; bus.opcode = 5'b11000;
    adv(P_F, 9); adv(P_E1, 9); adv(P_E2, 9);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_in_exec2", act(), 23'b0);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    adv(P_I, 0); adv(P_I, 0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the fetch/execute phase strobes (fe, e1, e2) that drive the instruction decoder and datapath.
- Sequences each instruction through FETCH, EXEC1 and, where needed, EXEC2 or a multiplier wait, based on the opcode in the instruction register.
- Handles run and single-step control, halting on STP, and multiplier timeout.
- Sits between the front-panel/debug control and the decoder, one instance per core.

Parameters:
- MUL_TIMEOUT, 16: max cycles to wait for mul_done before flagging an error (range 2..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = execute continuously.
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- clear  in  1  one-cycle pulse; leave HALT and return to IDLE, clearing the error flag.
- stall  in  1  memory not ready; extends FETCH.
- opcode  in  5  INSTR[15:11] from the instruction register, valid from EXEC1 onward.
- mul_done  in  1  multiplier result ready.
- fe  out  1  fetch strobe to the decoder.
- e1  out  1  execute-phase-1 strobe.
- e2  out  1  execute-phase-2 strobe.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- busy  out  1  1 in any state except IDLE and HALT.
- halted  out  1  1 in HALT.
- mul_err  out  1  sticky multiplier timeout flag.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- States: IDLE, FETCH, EXEC1, EXEC2, MUL_WAIT, HALT. One-hot or binary encoding is allowed.
- fe, e1, e2, busy and halted are decoded from the state register:
  - fe = FETCH, e1 = EXEC1, e2 = EXEC2.
  - Exactly one of fe, e1 or e2 is high at a time, or none.
- Reset, asynchronous while reset_n=0: state=IDLE; all outputs 0; instr_count=0; mul_err=0; the single-step flag ss=0. Reset mid-instruction aborts with no completion counted.
- Opcode classes:
  - STP = 00000.
  - MLR = 00111.
  - LDR = 01110.
  - LDA = opcode[4:2]==110.
  - All other opcodes are ordinary.
- IDLE:
  - run=1: go to FETCH with ss=0. run has priority if step arrives in the same cycle.
  - run=0 and step=1: go to FETCH with ss=1.
  - Otherwise stay in IDLE.
- FETCH: fe=1. While stall=1, stay in FETCH with fe held high (the read is idempotent). Otherwise go to EXEC1.
- EXEC1: e1=1 for exactly one cycle; it is never stretched.
  - STP: go to HALT; the instruction is not counted.
  - LDA or LDR: go to EXEC2.
  - MLR: mul_start=1 this cycle, load the timeout counter with MUL_TIMEOUT, go to MUL_WAIT.
  - Ordinary: complete.
- EXEC2: e2=1 for one cycle, then complete.
- MUL_WAIT: no strobes. The timeout counter decrements each cycle.
  - mul_done=1: complete. mul_done wins over expiry in the same cycle.
  - Counter reaches 0 without mul_done: set mul_err, go to HALT, instruction not counted.
  - mul_done seen in any other state is ignored.
- Complete (taken in the cycle that leaves EXEC1, EXEC2 or MUL_WAIT):
  - Increment instr_count.
  - Next state is IDLE if ss=1 or run=0; otherwise FETCH.
- Dropping run mid-instruction finishes the current instruction, then goes to IDLE.
- HALT: halted=1. clear=1 goes to IDLE, clears mul_err and ss. run, step and stall are ignored. clear in any other state is ignored.
- step pulses outside IDLE are ignored (not queued).
- Latency and throughput:
  - Ordinary instruction: 2 cycles (FETCH+EXEC1) with no stall.
  - LDA/LDR: 3 cycles.
  - MLR: 2 cycles + wait, where the wait lasts until mul_done.
  - Back-to-back instructions in run mode have no idle cycle between them.

Decomposition:
- Shared package holds:
  - opcode constants OP_STP, OP_MLR, OP_LDR, and the LDA prefix 3'b110;
  - state encoding localparams S_IDLE … S_HALT.
- Sub-module phase_op_class (combinational) maps opcode to is_stp, is_two_phase and is_mul. The same classification is reused by the decoder and formal checks.

Test Plan:
- Reset release; run=1; opcodes 00001, 00001 -> fe,e1,fe,e1 on consecutive cycles; instr_count=2 after 4 cycles.
- run=1; opcode 11001 (LDA) -> fe,e1,e2 in 3 cycles; instr_count increments once; opcode 01110 (LDR) behaves the same.
- run=0, step pulse, ordinary opcode -> one fe, one e1, then IDLE; busy low afterwards; instr_count +1; a second step mid-instruction is ignored.
- stall=1 for 3 cycles during FETCH -> fe high 4 cycles, e1 exactly 1 cycle.
- MLR with mul_done asserted 5 cycles after mul_start -> no strobes while waiting, count +1. Repeat with mul_done never asserted, MUL_TIMEOUT=16 -> HALT after 16 wait cycles, mul_err=1, halted=1; clear -> IDLE, mul_err=0.
- Opcode 00000 during run -> e1 once, then halted=1, count unchanged. Apply reset_n=0 in EXEC2 -> all outputs 0 immediately, instr_count=0.
